// File: rtl/ccta_pipe_acc.sv
// ccta_pipe_acc: two-stage pipelined three-operand compare/add unit
// with a saturating running accumulator of results.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous reset, active-high (priority over everything)
//   in_valid  A/B/C/ctrl valid this cycle
//   A, B, C   unsigned operands, WIDTH bits
//   ctrl      operation mode captured with the operands
//               00: max(A,B)+C        01: max(A,B)-min(A,B)
//               10: min(A,B)+C        11: |max-C| + |min-C|
//   acc_clr   synchronous clear of acc/acc_sat (clear-then-add if a result loads)
//   q         registered WIDTH+1 bit result
//   out_valid one-cycle pulse per result, two edges after the sample
//   acc       saturating sum of results since reset/clear
//   acc_sat   sticky: acc saturated since reset/clear
module ccta_pipe_acc #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned ACC_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  logic [WIDTH-1:0]     C,
    input  logic [1:0]           ctrl,
    input  logic                 acc_clr,
    output logic [WIDTH:0]       q,
    output logic                 out_valid,
    output logic [ACC_WIDTH-1:0] acc,
    output logic                 acc_sat
);

    localparam int unsigned QW  = WIDTH + 1;
    localparam int unsigned SW  = ACC_WIDTH + 1;

    // Stage-1 registers
    logic [WIDTH-1:0] mx;
    logic [WIDTH-1:0] mn;
    logic [WIDTH-1:0] c1;
    logic [1:0]       ctrl1;
    logic             v1;

    // Combinational stage-2 result and accumulator next values
    logic [QW-1:0]        q_next_c;
    logic [QW-1:0]        mx_e_c;
    logic [QW-1:0]        mn_e_c;
    logic [QW-1:0]        c_e_c;
    logic [QW-1:0]        dmx_c;
    logic [QW-1:0]        dmn_c;
    logic [ACC_WIDTH-1:0] acc_base_c;
    logic [SW-1:0]        sum_c;
    logic [ACC_WIDTH-1:0] acc_next_c;
    logic                 sat_next_c;

    // Stage 1: sort A/B, capture C and mode; data holds when no sample
    always_ff @(posedge clk) begin
        if (rst) begin
            v1    <= 1'b0;
            mx    <= '0;
            mn    <= '0;
            c1    <= '0;
            ctrl1 <= 2'b00;
        end else begin
            v1 <= in_valid;
            if (in_valid) begin
                mx    <= (A >= B) ? A : B;
                mn    <= (A >= B) ? B : A;
                c1    <= C;
                ctrl1 <= ctrl;
            end
        end
    end

    // Stage-2 arithmetic, all at WIDTH+1 bits so no mode can overflow
    always_comb begin
        mx_e_c   = QW'(mx);
        mn_e_c   = QW'(mn);
        c_e_c    = QW'(c1);
        dmx_c    = (mx_e_c >= c_e_c) ? (mx_e_c - c_e_c) : (c_e_c - mx_e_c);
        dmn_c    = (mn_e_c >= c_e_c) ? (mn_e_c - c_e_c) : (c_e_c - mn_e_c);
        q_next_c = '0;
        case (ctrl1)
            2'b00:   q_next_c = mx_e_c + c_e_c;
            2'b01:   q_next_c = mx_e_c - mn_e_c;
            2'b10:   q_next_c = mn_e_c + c_e_c;
            default: q_next_c = dmx_c + dmn_c;
        endcase
    end

    // Accumulator: clear applies before the add on a loading edge
    always_comb begin
        acc_base_c = acc_clr ? '0 : acc;
        sat_next_c = acc_clr ? 1'b0 : acc_sat;
        sum_c      = SW'(acc_base_c) + SW'(q_next_c);
        acc_next_c = acc_base_c;
        if (v1) begin
            if (sum_c[ACC_WIDTH]) begin
                acc_next_c = '1;
                sat_next_c = 1'b1;
            end else begin
                acc_next_c = sum_c[ACC_WIDTH-1:0];
            end
        end
    end

    // Stage 2 and accumulator registers
    always_ff @(posedge clk) begin
        if (rst) begin
            q         <= '0;
            out_valid <= 1'b0;
            acc       <= '0;
            acc_sat   <= 1'b0;
        end else begin
            out_valid <= v1;
            if (v1) begin
                q <= q_next_c;
            end
            acc     <= acc_next_c;
            acc_sat <= sat_next_c;
        end
    end

endmodule

// File: tb/tb_ccta_pipe_acc.sv
// Directed bench for ccta_pipe_acc (WIDTH=4, ACC_WIDTH=8) with
// hand-computed expected values.
module tb_ccta_pipe_acc;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [3:0] A;
    logic [3:0] B;
    logic [3:0] C;
    logic [1:0] ctrl;
    logic       acc_clr;
    logic [4:0] q;
    logic       out_valid;
    logic [7:0] acc;
    logic       acc_sat;

    int errors = 0;
    int checks = 0;

    ccta_pipe_acc #(.WIDTH(4), .ACC_WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .A         (A),
        .B         (B),
        .C         (C),
        .ctrl      (ctrl),
        .acc_clr   (acc_clr),
        .q         (q),
        .out_valid (out_valid),
        .acc       (acc),
        .acc_sat   (acc_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, advance past the edge, settle
    task automatic drv(input logic v, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] c, input logic [1:0] m, input logic clr);
        in_valid = v;
        A        = a;
        B        = b;
        C        = c;
        ctrl     = m;
        acc_clr  = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drv(1'b0, 4'h0, 4'h0, 4'h0, 2'b00, 1'b0);
    endtask

    task automatic expect_out(input string tag, input logic ov, input logic [4:0] eq,
                              input logic [7:0] eacc, input logic esat);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
        chk({tag, ".q"},         32'(q),         32'(eq));
        chk({tag, ".acc"},       32'(acc),       32'(eacc));
        chk({tag, ".acc_sat"},   32'(acc_sat),   32'(esat));
    endtask

    initial begin
        rst = 1'b1;
        // Reset held with a valid sample present
        drv(1'b1, 4'hF, 4'hF, 4'hF, 2'b00, 1'b0);
        drv(1'b1, 4'hF, 4'hF, 4'hF, 2'b00, 1'b0);
        expect_out("rst_hold", 1'b0, 5'd0, 8'd0, 1'b0);
        rst = 1'b0;
        idle();
        expect_out("post_rst", 1'b0, 5'd0, 8'd0, 1'b0);

        // Four modes, one per cycle, on A=4 B=1 C=9
        drv(1'b1, 4'h4, 4'h1, 4'h9, 2'b00, 1'b0);
        expect_out("mode_lat1", 1'b0, 5'd0, 8'd0, 1'b0);
        drv(1'b1, 4'h4, 4'h1, 4'h9, 2'b01, 1'b0);
        expect_out("mode00", 1'b1, 5'h0D, 8'd13, 1'b0);
        drv(1'b1, 4'h4, 4'h1, 4'h9, 2'b10, 1'b0);
        expect_out("mode01", 1'b1, 5'h03, 8'd16, 1'b0);
        drv(1'b1, 4'h4, 4'h1, 4'h9, 2'b11, 1'b0);
        expect_out("mode10", 1'b1, 5'h0A, 8'd26, 1'b0);
        idle();
        expect_out("mode11", 1'b1, 5'h0D, 8'd39, 1'b0);
        idle();
        expect_out("mode_end", 1'b0, 5'h0D, 8'd39, 1'b0);

        // Clear with no result loading
        drv(1'b0, 4'h0, 4'h0, 4'h0, 2'b00, 1'b1);
        expect_out("clr_idle", 1'b0, 5'h0D, 8'd0, 1'b0);

        // Back-to-back ctrl=00
        drv(1'b1, 4'h3, 4'hD, 4'hD, 2'b00, 1'b0);
        drv(1'b1, 4'hF, 4'h2, 4'hE, 2'b00, 1'b0);
        expect_out("b2b_0", 1'b1, 5'd26, 8'd26, 1'b0);
        drv(1'b1, 4'hD, 4'hD, 4'h5, 2'b00, 1'b0);
        expect_out("b2b_1", 1'b1, 5'd29, 8'd55, 1'b0);
        idle();
        expect_out("b2b_2", 1'b1, 5'd18, 8'd73, 1'b0);
        idle();
        expect_out("b2b_end", 1'b0, 5'd18, 8'd73, 1'b0);

        // Gap handling: 1,0,1 with ctrl=10
        drv(1'b0, 4'h0, 4'h0, 4'h0, 2'b00, 1'b1);
        expect_out("clr_gap", 1'b0, 5'd18, 8'd0, 1'b0);
        drv(1'b1, 4'h5, 4'h2, 4'h1, 2'b10, 1'b0);
        drv(1'b0, 4'h5, 4'h2, 4'h1, 2'b10, 1'b0);
        expect_out("gap_0", 1'b1, 5'd3, 8'd3, 1'b0);
        drv(1'b1, 4'h5, 4'h2, 4'h1, 2'b10, 1'b0);
        expect_out("gap_1", 1'b0, 5'd3, 8'd3, 1'b0);
        idle();
        expect_out("gap_2", 1'b1, 5'd3, 8'd6, 1'b0);
        idle();
        expect_out("gap_end", 1'b0, 5'd3, 8'd6, 1'b0);

        // Saturation: ctrl=11, A=B=0, C=F -> 30 per sample
        drv(1'b0, 4'h0, 4'h0, 4'h0, 2'b00, 1'b1);
        expect_out("clr_sat", 1'b0, 5'd3, 8'd0, 1'b0);
        drv(1'b1, 4'h0, 4'h0, 4'hF, 2'b11, 1'b0);
        for (int i = 1; i <= 10; i++) begin
            drv(1'b1, 4'h0, 4'h0, 4'hF, 2'b11, 1'b0);
            if (i <= 8)
                expect_out($sformatf("sat_%0d", i), 1'b1, 5'd30, 8'(30 * i), 1'b0);
            else
                expect_out($sformatf("sat_%0d", i), 1'b1, 5'd30, 8'd255, 1'b1);
        end
        idle();
        expect_out("sat_hold", 1'b1, 5'd30, 8'd255, 1'b1);
        idle();
        expect_out("sat_idle", 1'b0, 5'd30, 8'd255, 1'b1);

        // Clear on the same edge a result (q=13) loads
        drv(1'b1, 4'h4, 4'h1, 4'h9, 2'b00, 1'b0);
        drv(1'b0, 4'h0, 4'h0, 4'h0, 2'b00, 1'b1);
        expect_out("clr_load", 1'b1, 5'd13, 8'd13, 1'b0);
        idle();
        expect_out("clr_load_end", 1'b0, 5'd13, 8'd13, 1'b0);

        // Reset mid-pipeline discards two queued samples
        drv(1'b1, 4'h7, 4'h1, 4'h2, 2'b00, 1'b0);
        drv(1'b1, 4'h6, 4'h1, 4'h2, 2'b00, 1'b0);
        rst = 1'b1;
        drv(1'b0, 4'h0, 4'h0, 4'h0, 2'b00, 1'b0);
        expect_out("mid_rst", 1'b0, 5'd0, 8'd0, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            idle();
            expect_out($sformatf("after_rst_%0d", i), 1'b0, 5'd0, 8'd0, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
